rx_anc_phase_gen: RTL and testbench
===================================

Name: rx_anc_phase_gen

Overview:
- Parametrised multi-channel phase generator. Feeds the phase AXI-Stream input of the RX ANC DDS frequency-shift path.
- Replaces a free-running single accumulator with the following:
  - a handshaked stream;
  - NCHAN tones, spaced by a programmable per-channel increment step;
  - a programmable period with free-run, periodic and one-shot modes;
  - a linear chirp.
- Configuration is shadowed and takes effect only at period boundaries, so the phase is never glitched mid-period.

Parameters:
- PHASE_WIDTH 24: width of each channel phase and increment.
- NCHAN 2: number of phase channels, 1..8.
- CNT_WIDTH 24: width of the sample counter and of cfg_nsig.
- START_PH 24'h000000: reset and default start phase.
- DPH_INC 2048: reset value of the base phase increment.
- NSIG_DEF 32768: reset value of the period length.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- srst  in  1  synchronous soft reset; same effect as reset, applied on the clock edge.
- cfg_load  in  1  one-cycle strobe that captures all cfg_* inputs into the shadow registers.
- cfg_ph_inc  in  PHASE_WIDTH  base increment for channel 0; a value of 0 selects DPH_INC.
- cfg_ch_step  in  PHASE_WIDTH  extra increment per channel index.
- cfg_chirp  in  PHASE_WIDTH  signed increment delta applied per accepted beat.
- cfg_start_ph  in  PHASE_WIDTH  phase loaded at the start of each period.
- cfg_nsig  in  CNT_WIDTH  period length in beats; a value of 0 is treated as 1.
- cfg_mode  in  2  0 = free-run, 1 = periodic, 2 = one-shot, 3 = periodic.
- start  in  1  pulse; moves the block from IDLE to RUN.
- stop  in  1  pulse; requests a stop at the next period boundary.
- m_phase_tdata  out  NCHAN*PHASE_WIDTH  channel k occupies bits [k*PHASE_WIDTH +: PHASE_WIDTH].
- m_phase_tvalid  out  1  beat valid.
- m_phase_tlast  out  1  marks the last beat of a period.
- m_phase_tready  in  1  downstream ready.
- busy  out  1  high when state is RUN.
- count  out  CNT_WIDTH  index of the current beat within its period.

Behaviour:
- Reset / srst values:
  - state IDLE, tvalid 0, tlast 0, busy 0, count 0, stop_pend 0;
  - all channel phases = START_PH;
  - shadow registers: inc = DPH_INC, step 0, chirp 0, start_ph = START_PH, nsig = NSIG_DEF, mode periodic.
- Shadow capture:
  - cfg_load captures the inputs into a pending set.
  - The pending set is applied to the active set when leaving IDLE and on every accepted tlast beat.
  - A cfg_load in the same cycle as an application is captured after that application, so it waits for the next one.
- Per-channel increments: inc_k = inc + k*step, modulo 2^PHASE_WIDTH. These are registered when the active set is applied.
- Advance rule: a beat is accepted on tvalid && tready. Phases, count and the chirp advance only on an accepted beat.
  - tdata and tlast hold stable while tvalid && !tready.
- Output timing:
  - In RUN, tvalid = 1.
  - The first beat is presented on the cycle after start and carries start_ph on every channel.
  - tdata is registered. Latency from accept to the next phase is 1 cycle; full throughput is 1 beat/cycle.
- On accept of a non-last beat:
  - ph_k += inc_k;
  - inc_k += chirp (signed, wraps);
  - count += 1.
- tlast = (count == nsig-1).
- On accept of the tlast beat:
  - count returns to 0;
  - the active set is applied and inc_k is reloaded, un-chirped.
  - Mode 0 (free-run): phases continue accumulating, ph_k += inc_k using the old inc_k.
  - Mode 1 / 3 (periodic): ph_k = start_ph.
  - Mode 2 (one-shot): the block goes to IDLE; tvalid falls on the next cycle.
  - If stop_pend is set, the block goes to IDLE and stop_pend clears.
- State machine:
  - IDLE -> RUN on start.
  - RUN -> IDLE on an accepted tlast beat when in one-shot mode or when stop_pend is set.
  - start during RUN is ignored.
  - stop during IDLE is ignored.
  - start and stop in the same cycle from IDLE: the block enters RUN with stop_pend set.
- Entering RUN reloads ph_k = start_ph and count = 0.
- Wrap-around: all phase and increment arithmetic is modulo 2^PHASE_WIDTH, with no saturation.
- Mid-operation reset or srst returns the block to reset values on that edge (asynchronously for reset); tvalid drops with no further beats.

Test Plan:
- Reset values and default start: NCHAN=2, no cfg_load, start, tready=1.
  - ch0 = 0, 2048, 4096, …; ch1 identical because step = 0.
  - tlast on beat 32767; beat 32768 is phase 0 again (periodic).
- Backpressure: cfg_ph_inc=100, cfg_nsig=4, mode 1, tready toggled 1010…
  - tdata holds while tready=0.
  - Accepted ch0 sequence is 0, 100, 200, 300(tlast), 0, …
- Channel step and chirp: cfg_ph_inc=10, cfg_ch_step=5, cfg_chirp=1, nsig=3.
  - ch0 = 0, 10, 21(tlast); ch1 = 0, 15, 31(tlast); then both return to 0.
- One-shot with phase wrap: cfg_start_ph=24'hFFFFF0, inc=16, nsig=2, mode 2.
  - Beats are FFFFF0, 000000(tlast); tvalid = 0 afterwards and busy = 0.
- Mid-period cfg_load and stop:
  - Load inc=50 at count 1 of a 4-beat period running inc=100: the new increment applies only after tlast.
  - A stop at count 1 ends the run after that period's tlast.
- Asynchronous reset asserted mid-beat with tready=0: tvalid = 0 and count = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rx_anc_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rx_anc_phase_gen
//  Purpose  : Multi-channel, handshaked phase generator with shadowed config,
//             per-channel tone spacing, linear chirp and period/one-shot modes.
//  Revision : 1.0  initial release
// ============================================================================
module rx_anc_phase_gen #(
    parameter int                     PHASE_WIDTH = 24,
    parameter int                     NCHAN       = 2,
    parameter int                     CNT_WIDTH   = 24,
    parameter logic [PHASE_WIDTH-1:0] START_PH    = '0,
    parameter int                     DPH_INC     = 2048,
    parameter int                     NSIG_DEF    = 32768
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         srst,
    input  logic                         cfg_load,
    input  logic [PHASE_WIDTH-1:0]       cfg_ph_inc,
    input  logic [PHASE_WIDTH-1:0]       cfg_ch_step,
    input  logic [PHASE_WIDTH-1:0]       cfg_chirp,
    input  logic [PHASE_WIDTH-1:0]       cfg_start_ph,
    input  logic [CNT_WIDTH-1:0]         cfg_nsig,
    input  logic [1:0]                   cfg_mode,
    input  logic                         start,
    input  logic                         stop,
    output logic [NCHAN*PHASE_WIDTH-1:0] m_phase_tdata,
    output logic                         m_phase_tvalid,
    output logic                         m_phase_tlast,
    input  logic                         m_phase_tready,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         count
);

    localparam logic [0:0]             c_S_IDLE   = 1'b0;
    localparam logic [0:0]             c_S_RUN    = 1'b1;
    localparam logic [1:0]             c_M_FREE   = 2'd0;
    localparam logic [1:0]             c_M_PER    = 2'd1;
    localparam logic [1:0]             c_M_ONE    = 2'd2;
    localparam logic [PHASE_WIDTH-1:0] c_INC_DEF  = PHASE_WIDTH'(DPH_INC);
    localparam logic [CNT_WIDTH-1:0]   c_NSIG_DEF = CNT_WIDTH'(NSIG_DEF);
    localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE  = CNT_WIDTH'(1);

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   r_stop_pend;
    logic [CNT_WIDTH-1:0]   r_count;

    logic [PHASE_WIDTH-1:0] r_pend_inc;
    logic [PHASE_WIDTH-1:0] r_pend_step;
    logic [PHASE_WIDTH-1:0] r_pend_chirp;
    logic [PHASE_WIDTH-1:0] r_pend_start;
    logic [CNT_WIDTH-1:0]   r_pend_nsig;
    logic [1:0]             r_pend_mode;

    logic [PHASE_WIDTH-1:0] r_act_chirp;
    logic [CNT_WIDTH-1:0]   r_act_nsig;
    logic [1:0]             r_act_mode;

    logic                   w_valid;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_is_last;
    logic                   w_last_acc;
    logic                   w_enter;
    logic                   w_exit;
    logic                   w_apply;

    assign w_accept   = w_valid & m_phase_tready;
    assign w_is_last  = (r_count == (r_act_nsig - c_CNT_ONE));
    assign w_last_acc = w_accept & w_is_last;
    assign w_enter    = (r_state == c_S_IDLE) & start;
    assign w_exit     = w_last_acc & ((r_act_mode == c_M_ONE) | r_stop_pend);
    assign w_apply    = w_enter | w_last_acc;

    // Zero-valued inc/nsig are substituted at capture so the datapath never sees them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || srst) begin
            r_pend_inc   <= c_INC_DEF;
            r_pend_step  <= '0;
            r_pend_chirp <= '0;
            r_pend_start <= START_PH;
            r_pend_nsig  <= c_NSIG_DEF;
            r_pend_mode  <= c_M_PER;
        end else if (cfg_load) begin
            r_pend_inc   <= (cfg_ph_inc == '0) ? c_INC_DEF : cfg_ph_inc;
            r_pend_step  <= cfg_ch_step;
            r_pend_chirp <= cfg_chirp;
            r_pend_start <= cfg_start_ph;
            r_pend_nsig  <= (cfg_nsig == '0) ? c_CNT_ONE : cfg_nsig;
            r_pend_mode  <= cfg_mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || srst) begin
            r_act_chirp <= '0;
            r_act_nsig  <= c_NSIG_DEF;
            r_act_mode  <= c_M_PER;
        end else if (w_apply) begin
            r_act_chirp <= r_pend_chirp;
            r_act_nsig  <= r_pend_nsig;
            r_act_mode  <= r_pend_mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || srst) begin
            r_stop_pend <= 1'b0;
        end else if (r_state == c_S_IDLE) begin
            r_stop_pend <= start & stop;
        end else if (w_exit) begin
            r_stop_pend <= 1'b0;
        end else if (stop) begin
            r_stop_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || srst) begin
            r_count <= '0;
        end else if (w_enter || w_last_acc) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || srst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (start)  w_state_nxt = c_S_RUN;
            c_S_RUN:  if (w_exit) w_state_nxt = c_S_IDLE;
            default:              w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_valid = 1'b0;
        w_busy  = 1'b0;
        if (r_state == c_S_RUN) begin
            w_valid = 1'b1;
            w_busy  = 1'b1;
        end
    end

    assign m_phase_tvalid = w_valid;
    assign m_phase_tlast  = w_valid & w_is_last;
    assign busy           = w_busy;
    assign count          = r_count;

    generate
        for (genvar k = 0; k < NCHAN; k++) begin : g_chan
            localparam logic [PHASE_WIDTH-1:0] c_K = PHASE_WIDTH'(k);

            logic [PHASE_WIDTH-1:0] r_ph;
            logic [PHASE_WIDTH-1:0] r_inc;
            logic [PHASE_WIDTH-1:0] w_inc_new;

            assign w_inc_new = r_pend_inc + c_K * r_pend_step;

            // Free-run keeps accumulating with the chirped increment of the closing beat.
            always_ff @(posedge clk or posedge reset) begin
                if (reset || srst) begin
                    r_ph  <= START_PH;
                    r_inc <= c_INC_DEF;
                end else if (w_enter) begin
                    r_ph  <= r_pend_start;
                    r_inc <= w_inc_new;
                end else if (w_last_acc) begin
                    r_ph  <= (r_act_mode == c_M_FREE) ? (r_ph + r_inc) : r_pend_start;
                    r_inc <= w_inc_new;
                end else if (w_accept) begin
                    r_ph  <= r_ph + r_inc;
                    r_inc <= r_inc + r_act_chirp;
                end
            end

            assign m_phase_tdata[k*PHASE_WIDTH +: PHASE_WIDTH] = r_ph;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rx_anc_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_anc_phase_gen
//  Purpose  : Self-checking bench for rx_anc_phase_gen against a closed-form
//             phase model (start + n*inc + chirp*n(n-1)/2 per period).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rx_anc_phase_gen;

    localparam int PW = 24;
    localparam int NC = 2;
    localparam int CW = 24;
    localparam int DW = NC * PW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          srst = 1'b0;
    logic          cfg_load = 1'b0;
    logic [PW-1:0] cfg_ph_inc = '0;
    logic [PW-1:0] cfg_ch_step = '0;
    logic [PW-1:0] cfg_chirp = '0;
    logic [PW-1:0] cfg_start_ph = '0;
    logic [CW-1:0] cfg_nsig = '0;
    logic [1:0]    cfg_mode = 2'd1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready = 1'b0;
    logic          busy;
    logic [CW-1:0] count;

    int pass_cnt = 0;
    int total_cnt = 0;
    int hold_err = 0;

    logic [DW-1:0] q_data[$];
    logic          q_last[$];
    logic [CW-1:0] q_cnt[$];

    rx_anc_phase_gen #(
        .PHASE_WIDTH(PW), .NCHAN(NC), .CNT_WIDTH(CW),
        .START_PH(24'h000000), .DPH_INC(2048), .NSIG_DEF(32768)
    ) dut (
        .clk(clk), .reset(reset), .srst(srst), .cfg_load(cfg_load),
        .cfg_ph_inc(cfg_ph_inc), .cfg_ch_step(cfg_ch_step), .cfg_chirp(cfg_chirp),
        .cfg_start_ph(cfg_start_ph), .cfg_nsig(cfg_nsig), .cfg_mode(cfg_mode),
        .start(start), .stop(stop),
        .m_phase_tdata(tdata), .m_phase_tvalid(tvalid), .m_phase_tlast(tlast),
        .m_phase_tready(tready), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] m_ph(input logic [PW-1:0] base, input logic [PW-1:0] inck,
                                           input logic [PW-1:0] chirp, input int n);
        longint ntri;
        longint acc;
        ntri = (longint'(n) * (longint'(n) - 1)) / 2;
        acc  = longint'(base) + longint'(n) * longint'(inck) + longint'($signed(chirp)) * ntri;
        return acc[PW-1:0];
    endfunction

    task automatic do_reset();
        reset = 1'b1; srst = 1'b0; start = 1'b0; stop = 1'b0; cfg_load = 1'b0; tready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_cfg(input logic [PW-1:0] inc, input logic [PW-1:0] step,
                            input logic [PW-1:0] chirp, input logic [PW-1:0] sph,
                            input logic [CW-1:0] nsig, input logic [1:0] mode);
        cfg_ph_inc = inc; cfg_ch_step = step; cfg_chirp = chirp;
        cfg_start_ph = sph; cfg_nsig = nsig; cfg_mode = mode;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_srst();
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
    endtask

    // pat: 0 = always ready, 1 = 1010..., 2 = random
    task automatic collect(input int nb, input int pat, input int load_at, input int stop_at,
                           input int budget);
        int cyc, nacc;
        logic pv, pr, pl;
        logic [DW-1:0] pd;
        q_data.delete(); q_last.delete(); q_cnt.delete();
        hold_err = 0; cyc = 0; nacc = 0; pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0;
        while (nacc < nb && cyc < budget) begin
            case (pat)
                0:       tready = 1'b1;
                1:       tready = (cyc % 2 == 0);
                default: tready = ($urandom_range(0, 1) == 1);
            endcase
            cfg_load = (nacc == load_at);
            stop     = (nacc == stop_at);
            if (pv && !pr && (!tvalid || tdata !== pd || tlast !== pl)) hold_err++;
            if (tvalid && tready) begin
                q_data.push_back(tdata); q_last.push_back(tlast); q_cnt.push_back(count);
                nacc++;
            end
            pv = tvalid; pr = tready; pd = tdata; pl = tlast;
            cyc++;
            @(negedge clk);
        end
        cfg_load = 1'b0;
        stop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", tvalid); else pass_cnt++;
        total_cnt++; if (tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", tlast); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (tdata !== '0) $display("FAIL reset_tdata: got %h want 0", tdata); else pass_cnt++;
    endtask

    task automatic test_default();
        logic [DW-1:0] e;
        int n;
        do_reset();
        pulse_start();
        collect(32770, 0, -1, -1, 33000);
        total_cnt++;
        if (q_data.size() != 32770) $display("FAIL dflt_beats: got %0d want 32770", q_data.size());
        else pass_cnt++;
        for (int i = 0; i < q_data.size(); i++) begin
            if (i < 16 || i >= 32760) begin
                n = i % 32768;
                for (int k = 0; k < NC; k++) e[k*PW +: PW] = m_ph('0, 24'd2048, '0, n);
                total_cnt++;
                if (q_data[i] !== e || q_last[i] !== (n == 32767) || q_cnt[i] !== CW'(n))
                    $display("FAIL dflt_beat%0d: got %h/%b/%0d want %h/%b/%0d",
                             i, q_data[i], q_last[i], q_cnt[i], e, (n == 32767), n);
                else pass_cnt++;
            end
        end
        pulse_srst();
        total_cnt++;
        if (tvalid !== 1'b0 || count !== '0 || busy !== 1'b0)
            $display("FAIL srst_idle: got v=%b c=%0d b=%b want 0/0/0", tvalid, count, busy);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int exp0[5];
        exp0 = '{0, 100, 200, 300, 0};
        do_reset();
        load_cfg(24'd100, '0, '0, '0, 24'd4, 2'd1);
        pulse_start();
        collect(5, 1, -1, -1, 40);
        total_cnt++;
        if (hold_err != 0) $display("FAIL bp_hold: got %0d violations want 0", hold_err); else pass_cnt++;
        total_cnt++;
        if (q_data.size() != 5) $display("FAIL bp_beats: got %0d want 5", q_data.size());
        else begin
            pass_cnt++;
            for (int i = 0; i < 5; i++) begin
                total_cnt++;
                if (q_data[i][PW-1:0] !== PW'(exp0[i]) || q_last[i] !== (i == 3))
                    $display("FAIL bp_beat%0d: got %0d/%b want %0d/%b", i, q_data[i][PW-1:0], q_last[i], exp0[i], (i == 3));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_chirp();
        int exp0[3], exp1[3];
        exp0 = '{0, 10, 21};
        exp1 = '{0, 15, 31};
        do_reset();
        load_cfg(24'd10, 24'd5, 24'd1, '0, 24'd3, 2'd1);
        pulse_start();
        collect(6, 0, -1, -1, 20);
        total_cnt++;
        if (q_data.size() != 6) $display("FAIL chirp_beats: got %0d want 6", q_data.size());
        else begin
            pass_cnt++;
            for (int i = 0; i < 6; i++) begin
                total_cnt++;
                if (q_data[i] !== {PW'(exp1[i%3]), PW'(exp0[i%3])} || q_last[i] !== (i % 3 == 2))
                    $display("FAIL chirp_beat%0d: got %h/%b want %h/%b", i, q_data[i], q_last[i],
                             {PW'(exp1[i%3]), PW'(exp0[i%3])}, (i % 3 == 2));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        load_cfg(24'd16, '0, '0, 24'hFFFFF0, 24'd2, 2'd2);
        pulse_start();
        collect(2, 0, -1, -1, 10);
        total_cnt++;
        if (q_data.size() != 2) $display("FAIL os_beats: got %0d want 2", q_data.size());
        else begin
            pass_cnt++;
            total_cnt++;
            if (q_data[0] !== {24'hFFFFF0, 24'hFFFFF0} || q_last[0] !== 1'b0)
                $display("FAIL os_beat0: got %h/%b want fffff0fffff0/0", q_data[0], q_last[0]);
            else pass_cnt++;
            total_cnt++;
            if (q_data[1] !== '0 || q_last[1] !== 1'b1)
                $display("FAIL os_beat1: got %h/%b want 0/1", q_data[1], q_last[1]);
            else pass_cnt++;
        end
        repeat (2) begin
            total_cnt++;
            if (tvalid !== 1'b0 || busy !== 1'b0)
                $display("FAIL os_idle: got v=%b b=%b want 0/0", tvalid, busy);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_midcfg_stop();
        int exp0[12];
        exp0 = '{0, 100, 200, 300, 0, 50, 100, 150, 0, 50, 100, 150};
        do_reset();
        load_cfg(24'd100, '0, '0, '0, 24'd4, 2'd1);
        cfg_ph_inc = 24'd50;
        pulse_start();
        collect(12, 0, 1, 9, 30);
        total_cnt++;
        if (q_data.size() != 12) $display("FAIL mid_beats: got %0d want 12", q_data.size());
        else begin
            pass_cnt++;
            for (int i = 0; i < 12; i++) begin
                total_cnt++;
                if (q_data[i][PW-1:0] !== PW'(exp0[i]) || q_last[i] !== (i % 4 == 3))
                    $display("FAIL mid_beat%0d: got %0d/%b want %0d/%b", i, q_data[i][PW-1:0], q_last[i], exp0[i], (i % 4 == 3));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (tvalid !== 1'b0 || busy !== 1'b0)
            $display("FAIL stop_idle: got v=%b b=%b want 0/0", tvalid, busy);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        load_cfg(24'd100, '0, '0, '0, 24'd4, 2'd1);
        pulse_start();
        tready = 1'b1;
        repeat (2) @(negedge clk);
        tready = 1'b0;
        total_cnt++;
        if (count !== CW'(2) || tvalid !== 1'b1) $display("FAIL ar_pre: got c=%0d v=%b want 2/1", count, tvalid);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (tvalid !== 1'b0 || count !== '0 || busy !== 1'b0 || tlast !== 1'b0)
            $display("FAIL ar_async: got v=%b c=%0d b=%b l=%b want 0/0/0/0", tvalid, count, busy, tlast);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [PW-1:0] inc, step, chirp, sph, inc_eff;
        logic [CW-1:0] nsig;
        logic [1:0]    mode;
        logic [PW-1:0] base[NC];
        logic [PW-1:0] inck[NC];
        logic [DW-1:0] e;
        int ns, nb, n;
        do_reset();
        for (int it = 0; it < 8; it++) begin
            inc   = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom);
            step  = PW'($urandom);
            chirp = PW'($urandom);
            sph   = PW'($urandom);
            nsig  = CW'($urandom_range(0, 5));
            mode  = 2'($urandom_range(0, 3));
            inc_eff = (inc == '0) ? 24'd2048 : inc;
            ns = (nsig == '0) ? 1 : int'(nsig);
            nb = (mode == 2'd2) ? ns : 3 * ns;
            for (int k = 0; k < NC; k++) begin
                base[k] = sph;
                inck[k] = inc_eff + PW'(k) * step;
            end
            load_cfg(inc, step, chirp, sph, nsig, mode);
            pulse_start();
            collect(nb, 2, -1, -1, nb * 10 + 40);
            total_cnt++;
            if (hold_err != 0 || q_data.size() != nb)
                $display("FAIL rnd%0d_stream: got hold=%0d beats=%0d want 0/%0d", it, hold_err, q_data.size(), nb);
            else pass_cnt++;
            for (int i = 0; i < q_data.size(); i++) begin
                n = i % ns;
                if (i > 0 && n == 0 && mode == 2'd0)
                    for (int k = 0; k < NC; k++) base[k] = m_ph(base[k], inck[k], chirp, ns);
                for (int k = 0; k < NC; k++) e[k*PW +: PW] = m_ph(base[k], inck[k], chirp, n);
                total_cnt++;
                if (q_data[i] !== e || q_last[i] !== (n == ns - 1) || q_cnt[i] !== CW'(n))
                    $display("FAIL rnd%0d_beat%0d: got %h/%b/%0d want %h/%b/%0d",
                             it, i, q_data[i], q_last[i], q_cnt[i], e, (n == ns - 1), n);
                else pass_cnt++;
            end
            if (mode == 2'd2) begin
                total_cnt++;
                if (tvalid !== 1'b0) $display("FAIL rnd%0d_oneshot_idle: got v=%b want 0", it, tvalid);
                else pass_cnt++;
            end
            pulse_srst();
            total_cnt++;
            if (tvalid !== 1'b0 || count !== '0)
                $display("FAIL rnd%0d_srst: got v=%b c=%0d want 0/0", it, tvalid, count);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_backpressure();
        test_chirp();
        test_oneshot();
        test_midcfg_stop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
